// File: rtl/stereo_codec_buffer.sv
// rtl/stereo_codec_buffer.sv - stereo pair FIFO between panning stage and codec, with priming and sticky status
module stereo_codec_buffer #(
    parameter int DEPTH       = 8,
    parameter int PRIME_LEVEL = 4,
    parameter int CW          = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic signed [15:0]   in_L,
    input  logic signed [15:0]   in_R,
    input  logic                 in_valid,
    input  logic                 codec_req,
    input  logic                 clear_flags,
    output logic signed [15:0]   out_L,
    output logic signed [15:0]   out_R,
    output logic                 out_valid,
    output logic [CW-1:0]        count,
    output logic                 full,
    output logic                 empty,
    output logic                 overflow,
    output logic                 underflow
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic {PRIME, RUN} state_t;

    state_t        state;
    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [31:0]   held;
    logic [31:0]   head;
    logic          do_push;
    logic          do_pop;
    logic          ovf_ev;
    logic          unf_ev;
    logic [CW-1:0] count_next;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign head  = mem[rptr];

    // A full FIFO still accepts a push when the same cycle pops; an empty one never bypasses.
    always_comb begin
        do_pop     = (state == RUN) && codec_req && !empty;
        do_push    = in_valid && (!full || do_pop);
        ovf_ev     = in_valid && !do_push;
        unf_ev     = (state == RUN) && codec_req && empty;
        count_next = count;
        if (do_push && !do_pop)
            count_next = count + CW'(1);
        else if (!do_push && do_pop)
            count_next = count - CW'(1);
    end

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wptr] <= {in_L, in_R};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= PRIME;
            wptr      <= '0;
            rptr      <= '0;
            count     <= '0;
            held      <= '0;
            out_L     <= '0;
            out_R     <= '0;
            out_valid <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            count     <= count_next;
            out_valid <= codec_req;
            if (do_push)
                wptr <= wptr + AW'(1);
            if (do_pop)
                rptr <= rptr + AW'(1);

            if (codec_req) begin
                if (state == PRIME) begin
                    out_L <= '0;
                    out_R <= '0;
                end else if (do_pop) begin
                    out_L <= head[31:16];
                    out_R <= head[15:0];
                    held  <= head;
                end else begin
                    out_L <= held[31:16];
                    out_R <= held[15:0];
                end
            end

            // Set beats clear when both land in the same cycle.
            overflow  <= (overflow  & ~clear_flags) | ovf_ev;
            underflow <= (underflow & ~clear_flags) | unf_ev;

            case (state)
                PRIME: if (count_next >= CW'(PRIME_LEVEL)) state <= RUN;
                RUN:   if (unf_ev) state <= PRIME;
                default: state <= PRIME;
            endcase
        end
    end
endmodule
